// File: rtl/wb_stream_writer.sv
// wb_stream_writer: stream-to-memory DMA, buffers a valid/ready stream in a FIFO and writes it out as Wishbone incrementing bursts
module wb_stream_writer #(
  parameter int WB_AW = 32,
  parameter int WB_DW = 32,
  parameter int FIFO_AW = 6
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  output logic [WB_AW-1:0]   wbm_adr_o,
  output logic [WB_DW-1:0]   wbm_dat_o,
  output logic [WB_DW/8-1:0] wbm_sel_o,
  output logic               wbm_we_o,
  output logic               wbm_cyc_o,
  output logic               wbm_stb_o,
  output logic [2:0]         wbm_cti_o,
  output logic [1:0]         wbm_bte_o,
  input  logic               wbm_ack_i,
  input  logic               wbm_err_i,
  input  logic [WB_DW-1:0]   stream_s_data_i,
  input  logic               stream_s_valid_i,
  output logic               stream_s_ready_o,
  input  logic               enable,
  input  logic [WB_AW-1:0]   start_adr,
  input  logic [WB_AW-1:0]   buf_size,
  input  logic [WB_AW-1:0]   burst_size,
  output logic               busy,
  output logic [WB_DW-1:0]   tx_cnt,
  output logic               err
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW = FIFO_AW + 1;
  typedef enum logic [1:0] {IDLE, FILL, BURST} state_t;
  state_t state, state_n;
  logic [WB_DW-1:0] mem [0:DEPTH-1];
  logic [FIFO_AW-1:0] wptr, rptr;
  logic [CW-1:0] cnt;
  logic [WB_AW-1:0] adr, rem, blen, bcnt, beats;
  logic push, pop, fail, start, last, launch;
  assign push = stream_s_valid_i && stream_s_ready_o;
  assign pop = state == BURST && wbm_ack_i && !wbm_err_i;
  assign fail = state == BURST && wbm_err_i;
  assign start = state == IDLE && enable && buf_size != '0;
  assign beats = blen < rem ? blen : rem;
  assign last = bcnt == WB_AW'(1);
  assign launch = state == FILL && WB_AW'(cnt) >= beats;
  assign stream_s_ready_o = cnt != CW'(DEPTH);
  assign wbm_adr_o = adr;
  assign wbm_dat_o = mem[rptr];
  assign wbm_sel_o = '1;
  assign wbm_we_o = state == BURST;
  assign wbm_cyc_o = state == BURST;
  assign wbm_stb_o = state == BURST;
  assign wbm_cti_o = state == BURST ? (last ? 3'b111 : 3'b010) : 3'b000;
  assign wbm_bte_o = 2'b00;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    state_n = start ? FILL :
              launch ? BURST :
              fail ? IDLE :
              (pop && last) ? (rem == WB_AW'(1) ? IDLE : FILL) : state;
  end
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge wb_clk_i)
    if (push) mem[wptr] <= stream_s_data_i;
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      wptr <= '0;
      rptr <= '0;
      cnt <= '0;
    end else begin
      if (push) wptr <= wptr + FIFO_AW'(1);
      if (pop) rptr <= rptr + FIFO_AW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  // An errored beat is neither popped nor counted, so unsent data stays queued
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      adr <= '0;
      rem <= '0;
      blen <= '0;
      bcnt <= '0;
      tx_cnt <= '0;
      err <= 1'b0;
    end else begin
      if (start) begin
        adr <= start_adr;
        rem <= buf_size;
        blen <= burst_size == '0 ? WB_AW'(1) : burst_size > WB_AW'(DEPTH) ? WB_AW'(DEPTH) : burst_size;
        tx_cnt <= '0;
        err <= 1'b0;
      end
      if (launch) bcnt <= beats;
      if (pop) begin
        adr <= adr + WB_AW'(4);
        rem <= rem - WB_AW'(1);
        bcnt <= bcnt - WB_AW'(1);
        tx_cnt <= tx_cnt + WB_DW'(1);
      end
      if (fail) err <= 1'b1;
    end
endmodule

// File: tb/tb_wb_stream_writer.sv
// tb_wb_stream_writer: scoreboard bench, expected Wishbone beats queued with the stream stimulus and checked by a slave model
module tb_wb_stream_writer;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic [31:0] adr, dat, s_data = '0, start_adr = '0, buf_size = '0, burst_size = '0, tx_cnt;
  logic [3:0] sel;
  logic [2:0] cti;
  logic [1:0] bte;
  logic we, cyc, stb, ack = 1'b0, berr = 1'b0, s_valid = 1'b0, ready, enable = 1'b0, busy, err;
  typedef struct {logic [31:0] a; logic [31:0] d; logic [2:0] c;} beat_t;
  beat_t q[$];
  int compared = 0, mismatched = 0, beat_no = 0, err_at = -1;
  bit stall_en = 1'b0;

  wb_stream_writer dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbm_adr_o(adr), .wbm_dat_o(dat), .wbm_sel_o(sel), .wbm_we_o(we),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_cti_o(cti), .wbm_bte_o(bte),
    .wbm_ack_i(ack), .wbm_err_i(berr),
    .stream_s_data_i(s_data), .stream_s_valid_i(s_valid), .stream_s_ready_o(ready),
    .enable(enable), .start_adr(start_adr), .buf_size(buf_size), .burst_size(burst_size),
    .busy(busy), .tx_cnt(tx_cnt), .err(err)
  );

  task automatic slave;
    beat_t e;
    bit err_seen = 1'b0;
    forever begin
      @(negedge clk);
      ack = 1'b0;
      berr = 1'b0;
      if (err_seen) begin
        compared++;
        if (cyc !== 1'b0) begin mismatched++; $display("FAIL err_drop: cyc=%b want 0", cyc); end
        err_seen = 1'b0;
      end
      if (!rst && cyc && stb && !(stall_en && $urandom_range(0, 3) == 0)) begin
        if (beat_no == err_at) begin
          berr = 1'b1;
          err_seen = 1'b1;
        end else begin
          ack = 1'b1;
          beat_no++;
          compared++;
          if (q.size() == 0) begin
            mismatched++;
            $display("FAIL beat: unexpected write adr=%h dat=%h cti=%b", adr, dat, cti);
          end else begin
            e = q.pop_front();
            if (adr !== e.a || dat !== e.d || cti !== e.c || we !== 1'b1 || sel !== 4'hf || bte !== 2'b00) begin
              mismatched++;
              $display("FAIL beat: adr=%h dat=%h cti=%b we=%b sel=%h bte=%b want adr=%h dat=%h cti=%b we=1 sel=f bte=00",
                       adr, dat, cti, we, sel, bte, e.a, e.d, e.c);
            end
          end
        end
      end
    end
  endtask

  task automatic expect_xfer(input logic [31:0] a, input int n, input int burst, input logic [31:0] d0);
    int b = burst == 0 ? 1 : burst > 64 ? 64 : burst;
    beat_t x;
    for (int i = 0; i < n; i++) begin
      x.a = a + 32'(4 * i);
      x.d = d0 + 32'(i);
      x.c = ((i % b) == b - 1 || i == n - 1) ? 3'b111 : 3'b010;
      q.push_back(x);
    end
  endtask

  task automatic send(input int n, input logic [31:0] d0);
    int t;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data = d0 + 32'(i);
      t = 0;
      while (!ready && t < 500) begin @(negedge clk); t++; end
      if (!ready) begin compared++; mismatched++; $display("FAIL send_timeout: ready=%b want 1", ready); break; end
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic start(input logic [31:0] a, input logic [31:0] n, input logic [31:0] b);
    @(negedge clk);
    start_adr = a;
    buf_size = n;
    burst_size = b;
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
  endtask

  task automatic wait_idle;
    int t = 0;
    while (busy && t < 3000) begin @(negedge clk); t++; end
    if (busy) begin compared++; mismatched++; $display("FAIL idle_timeout: busy=%b want 0", busy); end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    compared++; if ({cyc, stb, busy, err} !== 4'b0000) begin mismatched++; $display("FAIL reset_ctl: cyc/stb/busy/err=%b want 0000", {cyc, stb, busy, err}); end
    compared++; if (tx_cnt !== 32'd0) begin mismatched++; $display("FAIL reset_tx_cnt: got %0d want 0", tx_cnt); end
    compared++; if (adr !== 32'd0 || cti !== 3'b000) begin mismatched++; $display("FAIL reset_bus: adr=%h cti=%b want 0 000", adr, cti); end
    compared++; if (ready !== 1'b1) begin mismatched++; $display("FAIL reset_ready: got %b want 1", ready); end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    stall_en = 1'b1;
    send(8, 32'd0);
    expect_xfer(32'h1000, 8, 4, 32'd0);
    start(32'h1000, 8, 4);
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL basic_busy: got %b want 1", busy); end
    compared++; if (stb !== 1'b0) begin mismatched++; $display("FAIL basic_stb_early: got %b want 0", stb); end
    wait_idle();
    compared++; if (tx_cnt !== 32'd8) begin mismatched++; $display("FAIL basic_tx_cnt: got %0d want 8", tx_cnt); end
    compared++; if (q.size() != 0) begin mismatched++; $display("FAIL basic_pending: got %0d want 0", q.size()); end
    compared++; if (cyc !== 1'b0 || err !== 1'b0) begin mismatched++; $display("FAIL basic_end: cyc=%b err=%b want 0 0", cyc, err); end
  endtask

  task automatic test_partial;
    send(5, 32'h100);
    expect_xfer(32'h2000, 5, 4, 32'h100);
    start(32'h2000, 5, 4);
    wait_idle();
    compared++; if (tx_cnt !== 32'd5) begin mismatched++; $display("FAIL partial_tx_cnt: got %0d want 5", tx_cnt); end
    compared++; if (q.size() != 0) begin mismatched++; $display("FAIL partial_pending: got %0d want 0", q.size()); end
  endtask

  task automatic test_full;
    int t = 0;
    send(64, 32'h1000_0000);
    compared++; if (ready !== 1'b0) begin mismatched++; $display("FAIL full_ready: got %b want 0", ready); end
    expect_xfer(32'h8000, 64, 16, 32'h1000_0000);
    start(32'h8000, 64, 16);
    while (tx_cnt == 32'd0 && t < 500) begin @(negedge clk); t++; end
    compared++; if (ready !== 1'b1 || tx_cnt !== 32'd1) begin mismatched++; $display("FAIL full_ready_return: ready=%b tx_cnt=%0d want 1 1", ready, tx_cnt); end
    start(32'h9000, 3, 1);
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL midstart_busy: got %b want 1", busy); end
    wait_idle();
    compared++; if (tx_cnt !== 32'd64) begin mismatched++; $display("FAIL full_tx_cnt: got %0d want 64", tx_cnt); end
    compared++; if (q.size() != 0) begin mismatched++; $display("FAIL full_pending: got %0d want 0", q.size()); end
  endtask

  task automatic test_zero;
    send(3, 32'hC0);
    expect_xfer(32'hFFFF_FFF8, 3, 0, 32'hC0);
    start(32'hFFFF_FFF8, 3, 0);
    wait_idle();
    compared++; if (tx_cnt !== 32'd3) begin mismatched++; $display("FAIL zero_tx_cnt: got %0d want 3", tx_cnt); end
    compared++; if (q.size() != 0) begin mismatched++; $display("FAIL zero_pending: got %0d want 0", q.size()); end
    start(32'h5000, 0, 4);
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL emptybuf_busy: got %b want 0", busy); end
    repeat (5) @(negedge clk);
    compared++; if (busy !== 1'b0 || cyc !== 1'b0 || tx_cnt !== 32'd3) begin mismatched++; $display("FAIL emptybuf_hold: busy=%b cyc=%b tx_cnt=%0d want 0 0 3", busy, cyc, tx_cnt); end
  endtask

  task automatic test_err;
    send(4, 32'hA0);
    expect_xfer(32'h3000, 4, 4, 32'hA0);
    err_at = beat_no + 2;
    start(32'h3000, 4, 4);
    wait_idle();
    err_at = -1;
    repeat (2) @(negedge clk);
    compared++; if (err !== 1'b1 || busy !== 1'b0) begin mismatched++; $display("FAIL err_flag: err=%b busy=%b want 1 0", err, busy); end
    compared++; if (tx_cnt !== 32'd2) begin mismatched++; $display("FAIL err_tx_cnt: got %0d want 2", tx_cnt); end
    compared++; if (q.size() != 2) begin mismatched++; $display("FAIL err_unsent: got %0d want 2", q.size()); end
    q.delete();
    expect_xfer(32'h4000, 2, 4, 32'hA2);
    start(32'h4000, 2, 4);
    compared++; if (err !== 1'b0) begin mismatched++; $display("FAIL err_clear: got %b want 0", err); end
    wait_idle();
    compared++; if (tx_cnt !== 32'd2 || q.size() != 0) begin mismatched++; $display("FAIL err_retained: tx_cnt=%0d pending=%0d want 2 0", tx_cnt, q.size()); end
  endtask

  task automatic test_rst_mid;
    int t = 0;
    send(8, 32'hD0);
    expect_xfer(32'h6000, 8, 8, 32'hD0);
    start(32'h6000, 8, 8);
    while (tx_cnt < 32'd2 && t < 500) begin @(negedge clk); t++; end
    #2 rst = 1'b1;
    #1;
    compared++; if ({cyc, stb, busy} !== 3'b000) begin mismatched++; $display("FAIL rst_mid_ctl: cyc/stb/busy=%b want 000", {cyc, stb, busy}); end
    compared++; if (tx_cnt !== 32'd0 || ready !== 1'b1) begin mismatched++; $display("FAIL rst_mid_state: tx_cnt=%0d ready=%b want 0 1", tx_cnt, ready); end
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    start(32'h7000, 1, 1);
    repeat (10) @(negedge clk);
    compared++; if (busy !== 1'b1 || cyc !== 1'b0) begin mismatched++; $display("FAIL rst_fifo_empty: busy=%b cyc=%b want 1 0", busy, cyc); end
    expect_xfer(32'h7000, 1, 1, 32'h55);
    send(1, 32'h55);
    wait_idle();
    compared++; if (tx_cnt !== 32'd1 || q.size() != 0) begin mismatched++; $display("FAIL rst_restart: tx_cnt=%0d pending=%0d want 1 0", tx_cnt, q.size()); end
  endtask

  initial begin
    fork
      slave();
    join_none
    test_reset();
    test_basic();
    test_partial();
    test_full();
    test_zero();
    test_err();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
